// File: rtl/drm_axil_initiator.sv
// AXI4-Lite single-outstanding initiator: one command in, one AXI transaction
// out, one response back. A bounded response wait turns a silent slave into a
// SLVERR-style timeout response; leftovers are drained while idle.
module drm_axil_initiator #(
  parameter int C_M_AXI_ADDR_WIDTH = 16,
  parameter int C_M_AXI_DATA_WIDTH = 32,
  parameter int C_TIMEOUT_CYCLES   = 1024
) (
  input  logic                            ap_clk,
  input  logic                            ap_rst_n,
  // command
  input  logic                            cmd_valid,
  output logic                            cmd_ready,
  input  logic                            cmd_write,
  input  logic [C_M_AXI_ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]   cmd_wdata,
  input  logic [C_M_AXI_DATA_WIDTH/8-1:0] cmd_wstrb,
  // response
  output logic                            rsp_valid,
  input  logic                            rsp_ready,
  output logic [C_M_AXI_DATA_WIDTH-1:0]   rsp_rdata,
  output logic [1:0]                      rsp_resp,
  output logic                            rsp_timeout,
  // AW / W / B
  output logic                            m_axi_control_awvalid,
  input  logic                            m_axi_control_awready,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]   m_axi_control_awaddr,
  output logic [2:0]                      m_axi_control_awprot,
  output logic                            m_axi_control_wvalid,
  input  logic                            m_axi_control_wready,
  output logic [C_M_AXI_DATA_WIDTH-1:0]   m_axi_control_wdata,
  output logic [C_M_AXI_DATA_WIDTH/8-1:0] m_axi_control_wstrb,
  input  logic                            m_axi_control_bvalid,
  output logic                            m_axi_control_bready,
  input  logic [1:0]                      m_axi_control_bresp,
  // AR / R
  output logic                            m_axi_control_arvalid,
  input  logic                            m_axi_control_arready,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]   m_axi_control_araddr,
  output logic [2:0]                      m_axi_control_arprot,
  input  logic                            m_axi_control_rvalid,
  output logic                            m_axi_control_rready,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]   m_axi_control_rdata,
  input  logic [1:0]                      m_axi_control_rresp,
  // status
  output logic                            busy
);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] WR_REQ  = 3'd1;
  localparam logic [2:0] WR_RESP = 3'd2;
  localparam logic [2:0] RD_REQ  = 3'd3;
  localparam logic [2:0] RD_RESP = 3'd4;
  localparam logic [2:0] RSP     = 3'd5;

  // Last wait-counter value at which a response is still accepted.
  localparam logic [15:0] TMO_LAST = 16'(C_TIMEOUT_CYCLES - 1);

  logic [2:0]                      state;
  logic [C_M_AXI_ADDR_WIDTH-1:0]   addr_q;
  logic [C_M_AXI_DATA_WIDTH-1:0]   wdata_q;
  logic [C_M_AXI_DATA_WIDTH/8-1:0] wstrb_q;
  logic                            aw_done;
  logic                            w_done;
  logic [15:0]                     wait_cnt;
  logic [C_M_AXI_DATA_WIDTH-1:0]   rdata_q;
  logic [1:0]                      resp_q;
  logic                            timeout_q;

  logic aw_fire;
  logic w_fire;
  logic aw_next;
  logic w_next;

  // Handshake decode and the running "beat completed" view of each channel.
  assign aw_fire = m_axi_control_awvalid & m_axi_control_awready;
  assign w_fire  = m_axi_control_wvalid & m_axi_control_wready;
  assign aw_next = aw_done | aw_fire;
  assign w_next  = w_done | w_fire;

  // Outputs are pure state/register decodes, so nothing depends on inputs
  // combinationally. bready/rready stay high in IDLE to swallow late
  // responses from a timed-out transaction.
  assign cmd_ready             = (state == IDLE);
  assign busy                  = (state != IDLE);
  assign m_axi_control_awvalid = (state == WR_REQ) && !aw_done;
  assign m_axi_control_wvalid  = (state == WR_REQ) && !w_done;
  assign m_axi_control_arvalid = (state == RD_REQ);
  assign m_axi_control_bready  = (state == WR_RESP) || (state == IDLE);
  assign m_axi_control_rready  = (state == RD_RESP) || (state == IDLE);
  assign m_axi_control_awaddr  = addr_q;
  assign m_axi_control_araddr  = addr_q;
  assign m_axi_control_wdata   = wdata_q;
  assign m_axi_control_wstrb   = wstrb_q;
  assign m_axi_control_awprot  = 3'b000;
  assign m_axi_control_arprot  = 3'b000;
  assign rsp_valid             = (state == RSP);
  assign rsp_rdata             = rdata_q;
  assign rsp_resp              = resp_q;
  assign rsp_timeout           = timeout_q;

  // Transaction sequencer: capture command, run request and response phases,
  // hold the response until it is consumed.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state     <= IDLE;
      addr_q    <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      aw_done   <= 1'b0;
      w_done    <= 1'b0;
      wait_cnt  <= '0;
      rdata_q   <= '0;
      resp_q    <= 2'b00;
      timeout_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            addr_q  <= cmd_addr;
            wdata_q <= cmd_wdata;
            wstrb_q <= cmd_wstrb;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
            state   <= cmd_write ? WR_REQ : RD_REQ;
          end
        end
        WR_REQ: begin
          aw_done <= aw_next;
          w_done  <= w_next;
          if (aw_next && w_next) begin
            wait_cnt <= '0;
            state    <= WR_RESP;
          end
        end
        RD_REQ: begin
          if (m_axi_control_arready) begin
            wait_cnt <= '0;
            state    <= RD_RESP;
          end
        end
        WR_RESP: begin
          if (m_axi_control_bvalid) begin
            rdata_q   <= '0;
            resp_q    <= m_axi_control_bresp;
            timeout_q <= 1'b0;
            state     <= RSP;
          end else if (wait_cnt == TMO_LAST) begin
            rdata_q   <= '0;
            resp_q    <= 2'b10;
            timeout_q <= 1'b1;
            state     <= RSP;
          end else begin
            wait_cnt <= wait_cnt + 16'd1;
          end
        end
        RD_RESP: begin
          if (m_axi_control_rvalid) begin
            rdata_q   <= m_axi_control_rdata;
            resp_q    <= m_axi_control_rresp;
            timeout_q <= 1'b0;
            state     <= RSP;
          end else if (wait_cnt == TMO_LAST) begin
            rdata_q   <= '0;
            resp_q    <= 2'b10;
            timeout_q <= 1'b1;
            state     <= RSP;
          end else begin
            wait_cnt <= wait_cnt + 16'd1;
          end
        end
        RSP: begin
          if (rsp_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_drm_axil_initiator.sv
// Directed bench for drm_axil_initiator with an 8-cycle response timeout.
// Inputs change just after the falling edge; outputs are checked there too.
module tb_drm_axil_initiator;

  logic        ap_clk;
  logic        ap_rst_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [15:0] cmd_addr;
  logic [31:0] cmd_wdata;
  logic [3:0]  cmd_wstrb;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;
  logic        rsp_timeout;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic [15:0] awaddr, araddr;
  logic [2:0]  awprot, arprot;
  logic [31:0] wdata, rdata;
  logic [3:0]  wstrb;
  logic [1:0]  bresp, rresp;
  logic        arvalid, arready, rvalid, rready;
  logic        busy;

  int checks = 0;
  int errors = 0;
  int aw_cnt = 0, w_cnt = 0, ar_cnt = 0, r_cnt = 0, b_cnt = 0;
  int aw0, w0, ar0, r0;

  drm_axil_initiator #(
    .C_M_AXI_ADDR_WIDTH(16),
    .C_M_AXI_DATA_WIDTH(32),
    .C_TIMEOUT_CYCLES  (8)
  ) dut (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_resp(rsp_resp), .rsp_timeout(rsp_timeout),
    .m_axi_control_awvalid(awvalid), .m_axi_control_awready(awready),
    .m_axi_control_awaddr(awaddr), .m_axi_control_awprot(awprot),
    .m_axi_control_wvalid(wvalid), .m_axi_control_wready(wready),
    .m_axi_control_wdata(wdata), .m_axi_control_wstrb(wstrb),
    .m_axi_control_bvalid(bvalid), .m_axi_control_bready(bready),
    .m_axi_control_bresp(bresp),
    .m_axi_control_arvalid(arvalid), .m_axi_control_arready(arready),
    .m_axi_control_araddr(araddr), .m_axi_control_arprot(arprot),
    .m_axi_control_rvalid(rvalid), .m_axi_control_rready(rready),
    .m_axi_control_rdata(rdata), .m_axi_control_rresp(rresp),
    .busy(busy)
  );

  initial ap_clk = 1'b0;
  always #5 ap_clk = ~ap_clk;

  // Handshake counters observed at the active edge.
  always @(posedge ap_clk) begin
    if (awvalid && awready) aw_cnt <= aw_cnt + 1;
    if (wvalid && wready)   w_cnt  <= w_cnt + 1;
    if (arvalid && arready) ar_cnt <= ar_cnt + 1;
    if (rvalid && rready)   r_cnt  <= r_cnt + 1;
    if (bvalid && bready)   b_cnt  <= b_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge ap_clk);
  endtask

  initial begin
    ap_rst_n = 1'b0;
    cmd_valid = 0; cmd_write = 0; cmd_addr = '0; cmd_wdata = '0; cmd_wstrb = '0;
    rsp_ready = 1;
    awready = 0; wready = 0; arready = 0;
    bvalid = 0; bresp = 0; rvalid = 0; rdata = 0; rresp = 0;
    tick(); tick();

    // ---------------- reset state
    check("rst_cmd_ready", cmd_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_awvalid", awvalid, 0);
    check("rst_wvalid", wvalid, 0);
    check("rst_arvalid", arvalid, 0);
    check("rst_bready", bready, 1);
    check("rst_rready", rready, 1);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_awaddr", awaddr, 0);
    check("rst_rsp_resp", rsp_resp, 0);
    ap_rst_n = 1'b1;
    tick();

    // ---------------- write, simultaneous AW/W, bresp after 3 cycles
    aw0 = aw_cnt; w0 = w_cnt;
    awready = 1; wready = 1;
    cmd_valid = 1; cmd_write = 1; cmd_addr = 16'h0040; cmd_wdata = 32'hDEADBEEF; cmd_wstrb = 4'hF;
    tick();
    cmd_valid = 0;
    check("wr_awvalid", awvalid, 1);
    check("wr_wvalid", wvalid, 1);
    check("wr_awaddr", awaddr, 32'h0040);
    check("wr_wdata", wdata, 32'hDEADBEEF);
    check("wr_wstrb", wstrb, 4'hF);
    check("wr_awprot", awprot, 0);
    check("wr_busy", busy, 1);
    check("wr_cmd_ready", cmd_ready, 0);
    tick();
    check("wr_aw_drop", awvalid, 0);
    check("wr_w_drop", wvalid, 0);
    check("wr_bready", bready, 1);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("wr_wait_no_rsp", rsp_valid, 0);
    end
    bvalid = 1; bresp = 2'b00;
    tick();
    bvalid = 0;
    check("wr_rsp_valid", rsp_valid, 1);
    check("wr_rsp_resp", rsp_resp, 0);
    check("wr_rsp_rdata", rsp_rdata, 0);
    check("wr_rsp_timeout", rsp_timeout, 0);
    check("wr_rsp_bready", bready, 0);
    check("wr_aw_beats", aw_cnt - aw0, 1);
    check("wr_w_beats", w_cnt - w0, 1);
    tick();
    check("wr_back_idle", cmd_ready, 1);
    check("wr_idle_rsp_valid", rsp_valid, 0);

    // ---------------- read, arready delayed 2 cycles
    awready = 0; wready = 0; arready = 0;
    cmd_valid = 1; cmd_write = 0; cmd_addr = 16'h0010;
    tick();
    cmd_valid = 0;
    check("rd_arvalid", arvalid, 1);
    check("rd_araddr", araddr, 32'h0010);
    check("rd_arprot", arprot, 0);
    check("rd_req_rready", rready, 0);
    tick();
    check("rd_arvalid_hold", arvalid, 1);
    arready = 1;
    tick();
    arready = 0;
    check("rd_ar_drop", arvalid, 0);
    check("rd_rready", rready, 1);
    rvalid = 1; rdata = 32'h12345678; rresp = 2'b00;
    tick();
    rvalid = 0; rdata = 0;
    check("rd_rsp_valid", rsp_valid, 1);
    check("rd_rsp_rdata", rsp_rdata, 32'h12345678);
    check("rd_rsp_resp", rsp_resp, 0);
    check("rd_rsp_timeout", rsp_timeout, 0);
    tick();

    // ---------------- ordering: W first, AW 5 cycles later
    aw0 = aw_cnt; w0 = w_cnt;
    awready = 0; wready = 1;
    cmd_valid = 1; cmd_write = 1; cmd_addr = 16'h0044; cmd_wdata = 32'h11223344; cmd_wstrb = 4'h3;
    tick();
    cmd_valid = 0;
    check("ow_both_valid", {awvalid, wvalid}, 2'b11);
    tick();
    wready = 0;
    check("ow_w_drop", wvalid, 0);
    check("ow_aw_hold", awvalid, 1);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("ow_wait_valids", {awvalid, wvalid, bready}, 3'b100);
    end
    awready = 1;
    tick();
    awready = 0;
    check("ow_resp_phase", {awvalid, wvalid, bready}, 3'b001);
    check("ow_aw_beats", aw_cnt - aw0, 1);
    check("ow_w_beats", w_cnt - w0, 1);
    bvalid = 1; bresp = 2'b11;
    tick();
    bvalid = 0;
    check("ow_rsp_resp", rsp_resp, 2'b11);
    tick();

    // ---------------- ordering: AW first, W 5 cycles later
    aw0 = aw_cnt; w0 = w_cnt;
    awready = 1; wready = 0;
    cmd_valid = 1; cmd_write = 1; cmd_addr = 16'h0048; cmd_wdata = 32'hCAFEF00D; cmd_wstrb = 4'hC;
    tick();
    cmd_valid = 0;
    tick();
    awready = 0;
    check("oa_aw_drop", awvalid, 0);
    check("oa_w_hold", wvalid, 1);
    check("oa_wdata", wdata, 32'hCAFEF00D);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("oa_wait_valids", {awvalid, wvalid, bready}, 3'b010);
    end
    wready = 1;
    tick();
    wready = 0;
    check("oa_resp_phase", {awvalid, wvalid, bready}, 3'b001);
    check("oa_aw_beats", aw_cnt - aw0, 1);
    check("oa_w_beats", w_cnt - w0, 1);
    bvalid = 1; bresp = 2'b00;
    tick();
    bvalid = 0;
    check("oa_rsp_valid", rsp_valid, 1);
    tick();

    // ---------------- read timeout with response backpressure, then drain
    arready = 1;
    cmd_valid = 1; cmd_write = 0; cmd_addr = 16'h0020;
    tick();
    cmd_valid = 0;
    rsp_ready = 0;
    tick();
    arready = 0;
    check("to_first_wait", rready, 1);
    for (int i = 0; i < 7; i++) begin
      tick();
      check("to_waiting", {rready, rsp_valid}, 2'b10);
    end
    tick();
    check("to_rsp_valid", rsp_valid, 1);
    check("to_rsp_timeout", rsp_timeout, 1);
    check("to_rsp_resp", rsp_resp, 2'b10);
    check("to_rsp_rdata", rsp_rdata, 0);
    check("to_rready_drop", rready, 0);
    for (int i = 0; i < 10; i++) begin
      tick();
      check("bp_hold", {rsp_valid, rsp_timeout, rsp_resp, cmd_ready}, 5'b11100);
      check("bp_rdata", rsp_rdata, 0);
    end
    r0 = r_cnt;
    rsp_ready = 1;
    rvalid = 1; rdata = 32'h00000BAD;
    tick();
    check("dr_idle", {cmd_ready, rready}, 2'b11);
    tick();
    rvalid = 0; rdata = 0;
    check("dr_no_rsp", {rsp_valid, busy}, 2'b00);
    check("dr_r_beats", r_cnt - r0, 1);

    // ---------------- command arriving while busy waits for IDLE
    ar0 = ar_cnt; aw0 = aw_cnt;
    arready = 1;
    cmd_valid = 1; cmd_write = 0; cmd_addr = 16'h0030;
    tick();
    cmd_valid = 0;
    tick();
    arready = 0;
    rvalid = 1; rdata = 32'h0000A5A5;
    tick();
    rvalid = 0; rdata = 0;
    check("bz_rd_rdata", rsp_rdata, 32'h0000A5A5);
    cmd_valid = 1; cmd_write = 1; cmd_addr = 16'h0050; cmd_wdata = 32'h00C0FFEE; cmd_wstrb = 4'h1;
    tick();
    check("bz_idle_ready", cmd_ready, 1);
    tick();
    cmd_valid = 0;
    check("bz_wr_issued", awvalid, 1);
    check("bz_wr_addr", awaddr, 32'h0050);
    check("bz_ar_beats", ar_cnt - ar0, 1);
    awready = 1; wready = 1;
    tick();
    awready = 0; wready = 0;
    bvalid = 1; bresp = 2'b00;
    tick();
    bvalid = 0;
    check("bz_wr_rsp", {rsp_valid, rsp_resp}, 3'b100);
    tick();
    tick();
    check("bz_aw_beats", aw_cnt - aw0, 1);
    check("bz_no_reissue", busy, 0);

    // ---------------- asynchronous reset while awvalid is high
    awready = 0; wready = 0;
    cmd_valid = 1; cmd_write = 1; cmd_addr = 16'h0060; cmd_wdata = 32'h55AA55AA; cmd_wstrb = 4'hF;
    tick();
    cmd_valid = 0;
    check("rs_awvalid_before", awvalid, 1);
    #2 ap_rst_n = 1'b0;
    #1;
    check("rs_awvalid_now", awvalid, 0);
    check("rs_busy_now", busy, 0);
    check("rs_cmd_ready_now", cmd_ready, 1);
    check("rs_awaddr_clr", awaddr, 0);
    tick();
    ap_rst_n = 1'b1;
    tick();
    check("rs_no_rsp", rsp_valid, 0);
    arready = 1;
    cmd_valid = 1; cmd_write = 0; cmd_addr = 16'h0008;
    tick();
    cmd_valid = 0;
    check("rs_rd_araddr", araddr, 32'h0008);
    tick();
    arready = 0;
    rvalid = 1; rdata = 32'h0F0F0F0F; rresp = 2'b01;
    tick();
    rvalid = 0; rdata = 0; rresp = 0;
    check("rs_rd_rdata", rsp_rdata, 32'h0F0F0F0F);
    check("rs_rd_resp", rsp_resp, 2'b01);
    check("rs_rd_valid", rsp_valid, 1);
    tick();
    check("rs_done_idle", cmd_ready, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/drm_axil_initiator.md
DRM_AXIL_INITIATOR -- requirements
Module: drm_axil_initiator

Interface
REQ-001 SHALL have parameter C_M_AXI_ADDR_WIDTH, default 16: AXI4-Lite address width.
REQ-002 SHALL have parameter C_M_AXI_DATA_WIDTH, default 32: AXI4-Lite data width; only 32 is supported.
REQ-003 SHALL have parameter C_TIMEOUT_CYCLES, default 1024: response-wait limit in cycles, range 2..65535.
REQ-004 SHALL use one clock and an asynchronous, active-low reset, with ports as follows:
- ap_clk  in  1  clock
- ap_rst_n  in  1  asynchronous active-low reset
REQ-005 SHALL have these command ports:
- cmd_valid  in  1  command request
- cmd_ready  out  1  command accepted
- cmd_write  in  1  1=write, 0=read
- cmd_addr  in  ADDR  register byte address
- cmd_wdata  in  32  write data
- cmd_wstrb  in  4  write strobes
REQ-006 SHALL have these response ports:
- rsp_valid  out  1  response available
- rsp_ready  in  1  response consumed
- rsp_rdata  out  32  read data; 0 for writes
- rsp_resp  out  2  AXI response code
- rsp_timeout  out  1  response-wait expired
REQ-007 SHALL have these write-channel master ports:
- m_axi_control_awvalid/awready/awaddr[ADDR]/awprot[3]  out/in/out/out  AW channel
- m_axi_control_wvalid/wready/wdata[32]/wstrb[4]  out/in/out/out  W channel
- m_axi_control_bvalid/bready/bresp[2]  in/out/in  B channel
REQ-008 SHALL have these read-channel master ports:
- m_axi_control_arvalid/arready/araddr[ADDR]/arprot[3]  out/in/out/out  AR channel
- m_axi_control_rvalid/rready/rdata[32]/rresp[2]  in/out/in/in  R channel
REQ-009 SHALL have port busy  out  1: high whenever the state machine is not in IDLE.

Function
REQ-010 SHALL implement the states IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP and RSP.
REQ-011 SHALL drive cmd_ready=1 only in IDLE; cmd_ready is decoded combinationally from the state.
REQ-012 SHALL register cmd_addr, cmd_wdata and cmd_wstrb on a command handshake in cycle N and hold them until the next accepted command.
REQ-013 SHALL move IDLE->WR_REQ (cmd_write=1) or IDLE->RD_REQ (cmd_write=0) in cycle N and assert awvalid+wvalid or arvalid from cycle N+1.
REQ-014 WR_REQ: awvalid and wvalid SHALL each deassert the cycle after their own handshake; the block SHALL enter WR_RESP once both have completed, in any order or simultaneously.
REQ-015 RD_REQ: arvalid SHALL hold until the arready handshake, then the block SHALL enter RD_RESP.
REQ-016 awvalid, wvalid and arvalid SHALL never drop before their handshake, and addr/data/strb SHALL stay stable while valid is high.
REQ-017 awprot and arprot SHALL be constant 3'b000.
REQ-018 SHALL assert bready only in WR_RESP and rready only in RD_RESP, apart from the drain case in REQ-024.
REQ-019 On a B or R handshake, SHALL capture bresp or rresp/rdata and enter RSP the next cycle with rsp_valid=1 and rsp_timeout=0.
REQ-020 A 16-bit wait counter SHALL clear on entry to WR_RESP/RD_RESP and increment each cycle there without a handshake.
REQ-021 When the wait counter reaches C_TIMEOUT_CYCLES-1 without a handshake, the block SHALL:
- drop bready/rready;
- enter RSP with rsp_timeout=1, rsp_resp=2'b10, rsp_rdata=0.
REQ-022 The request states (WR_REQ, RD_REQ) SHALL have no timeout.
REQ-023 RSP: rsp_valid and all rsp_* outputs SHALL hold until rsp_ready=1, then the block SHALL return to IDLE; this permits back-to-back commands at one per transaction plus 2 cycles minimum.
REQ-024 Drain: in IDLE the block SHALL assert bready and rready, and discard any late bvalid/rvalid left over from a timed-out transaction without generating a response.
REQ-025 SHALL accept a cmd_valid that arrives while busy only at the next IDLE; it SHALL neither be lost nor double-issued.

Reset
REQ-026 When ap_rst_n=0, the block SHALL enter IDLE asynchronously and clear the wait counter and all captured data.
REQ-027 During reset, every output SHALL be 0 except cmd_ready and bready/rready, which follow REQ-011 and REQ-024.
REQ-028 On reset assertion mid-transaction, the block SHALL abandon the transaction with no response; release SHALL be synchronous to ap_clk.

Verification
REQ-029 Write path: write 0x0040 data 0xDEADBEEF strb 0xF, responder bresp=00 after 3 cycles -> one AW and one W beat, then rsp_valid with rsp_resp=00, rsp_rdata=0, rsp_timeout=0.
REQ-030 Read path: read 0x0010, responder returns rdata=0x12345678 rresp=00 -> rsp_rdata=0x12345678 one cycle after the R handshake.
REQ-031 Ordering: wready precedes awready by 5 cycles, then the reverse -> each valid drops exactly once and WR_RESP is entered in both orders.
REQ-032 Timeout: C_TIMEOUT_CYCLES=8, read with no rvalid -> after 8 wait cycles rsp_timeout=1 and rsp_resp=10; a late rvalid is drained in IDLE.
REQ-033 Backpressure: rsp_ready=0 for 10 cycles -> rsp_* remain stable and cmd_ready stays 0 throughout.
REQ-034 Reset: ap_rst_n pulsed low while awvalid=1 -> awvalid=0 immediately, busy=0, and a subsequent command completes normally.
